case_9_mul_pipe_hs: RTL and testbench

//  Parametrised pipelined integer multiplier with valid/ready flow control and global clock enable.

---
 rtl/case_9_mul_pkg.sv | 23 ++
 rtl/case_9_mul_pipe_slice.sv | 22 ++
 rtl/case_9_mul_pipe_hs.sv | 75 +++++++
 tb/tb_case_9_mul_pipe_hs.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_9_mul_pkg.sv
// case_9_mul_pkg: shared widths, output modes and result formatting for the case_9 pipelined multiplier.
package case_9_mul_pkg;
    localparam int MAXW = 64;
    localparam bit SAT_WRAP = 1'b0;
    localparam bit SAT_CLAMP = 1'b1;

    function automatic int prod_width(input int w0, input int w1, input bit s0, input bit s1);
        return w0 + w1 + ((s0 != s1) ? 1 : 0);
    endfunction

    // prod arrives already extended to MAXW; the caller keeps the low dw bits of the data field.
    function automatic logic [MAXW:0] fmt_result(input logic [MAXW-1:0] prod, input int p, input int dw,
                                                 input bit sgn, input bit mode);
        logic [MAXW-1:0] mask, low, ext, lim;
        logic ovf;
        mask = (dw >= MAXW) ? '1 : ((MAXW'(1) << dw) - MAXW'(1));
        low = prod & mask;
        ext = (sgn && ((low & (mask ^ (mask >> 1))) != '0)) ? (low | ~mask) : low;
        ovf = (dw < p) && (ext != prod);
        lim = !sgn ? mask : prod[MAXW-1] ? (~mask | (MAXW'(1) << (dw - 1))) : (mask >> 1);
        return {ovf, (ovf && mode == SAT_CLAMP) ? lim : prod};
    endfunction
endpackage

// File: rtl/case_9_mul_pipe_slice.sv
// case_9_mul_pipe_slice: one pipeline stage, a valid bit plus data register with load/bubble-collapse control.
module case_9_mul_pipe_slice #(
    parameter int W = 8,
    parameter bit RST_DATA = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv_in,
    input  logic         adv_out,
    input  logic         v_in,
    input  logic [W-1:0] d,
    output logic         v,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) v <= 1'b0;
        else if (adv_in) v <= v_in;
        else if (adv_out) v <= 1'b0;
        if (RST_DATA && !rst_n) q <= '0;
        else if (adv_in && v_in) q <= d;
    end
endmodule

// File: rtl/case_9_mul_pipe_hs.sv
// case_9_mul_pipe_hs: pipelined multiplier with valid/ready flow control, clock enable and wrap/saturate output.
module case_9_mul_pipe_hs
    import case_9_mul_pkg::*;
#(
    parameter int ID = 1,
    parameter int NUM_STAGE = 3,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 26,
    parameter int SIGNED0 = 1,
    parameter int SIGNED1 = 1,
    parameter int SAT_MODE = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_ovf
);
    localparam int N = NUM_STAGE;
    localparam bit SGN = (SIGNED0 != 0) || (SIGNED1 != 0);
    localparam int P = prod_width(din0_WIDTH, din1_WIDTH, SIGNED0 != 0, SIGNED1 != 0);
    localparam int WOP = din0_WIDTH + din1_WIDTH;

    logic en;
    logic [N:0] v, adv;
    logic [WOP-1:0] ops;
    logic [P-1:0] a_x, b_x;
    logic [P-1:0] pq [1:N-1];
    logic [MAXW:0] fmt;
    logic [dout_WIDTH:0] res;

    // Reset gates the enable so nothing transfers and in_ready reads 0 while in reset.
    assign en = ce & ap_rst_n;
    assign v[0] = in_valid;
    assign adv[N] = en & out_ready;
    for (genvar k = 0; k < N; k++) begin : g_adv
        assign adv[k] = en & (~v[k+1] | adv[k+1]);
    end
    assign in_ready = adv[0];

    case_9_mul_pipe_slice #(.W(WOP)) u_s1 (
        .clk(ap_clk), .rst_n(ap_rst_n), .adv_in(adv[0]), .adv_out(adv[1]),
        .v_in(v[0]), .d({din0, din1}), .v(v[1]), .q(ops)
    );

    // Operands are extended to P bits so the low P bits of the product are exact for any signedness mix.
    assign a_x = (SIGNED0 != 0) ? P'(signed'(ops[WOP-1:din1_WIDTH])) : P'(ops[WOP-1:din1_WIDTH]);
    assign b_x = (SIGNED1 != 0) ? P'(signed'(ops[din1_WIDTH-1:0])) : P'(ops[din1_WIDTH-1:0]);
    assign pq[1] = a_x * b_x;

    for (genvar k = 2; k < N; k++) begin : g_mid
        case_9_mul_pipe_slice #(.W(P)) u_s (
            .clk(ap_clk), .rst_n(ap_rst_n), .adv_in(adv[k-1]), .adv_out(adv[k]),
            .v_in(v[k-1]), .d(pq[k-1]), .v(v[k]), .q(pq[k])
        );
    end

    assign fmt = fmt_result(SGN ? MAXW'(signed'(pq[N-1])) : MAXW'(pq[N-1]), P, dout_WIDTH, SGN, SAT_MODE != 0);

    case_9_mul_pipe_slice #(.W(dout_WIDTH + 1), .RST_DATA(1'b1)) u_sn (
        .clk(ap_clk), .rst_n(ap_rst_n), .adv_in(adv[N-1]), .adv_out(adv[N]),
        .v_in(v[N-1]), .d({fmt[MAXW], fmt[dout_WIDTH-1:0]}), .v(v[N]), .q(res)
    );

    assign out_valid = v[N];
    assign dout = res[dout_WIDTH-1:0];
    assign dout_ovf = res[dout_WIDTH];
endmodule

// File: tb/tb_case_9_mul_pipe_hs.sv
// tb_case_9_mul_pipe_hs: directed scoreboard bench driving five parameter sets of the multiplier in lockstep.
module tb_case_9_mul_pipe_hs;
    logic ap_clk = 1'b0;
    logic ap_rst_n, ce, in_valid, out_ready;
    logic [13:0] din0;
    logic [11:0] din1;
    logic in_ready, out_valid, dout_ovf;
    logic [25:0] dout;
    logic s_rdy, s_vld, s_ovf, w_rdy, w_vld, w_ovf, u_rdy, u_vld, u_ovf, m_rdy, m_vld, m_ovf;
    logic [7:0] s_dout, w_dout;
    logic [25:0] u_dout, m_dout;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        logic [25:0] m;
        logic [7:0] s8;
        logic s8o;
        logic [7:0] w8;
        logic w8o;
        logic [25:0] uu;
        logic [25:0] su;
        logic suo;
    } exp_t;
    exp_t exp_q[$];

    always #5 ap_clk = ~ap_clk;

    case_9_mul_pipe_hs dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_ovf(dout_ovf)
    );
    case_9_mul_pipe_hs #(.dout_WIDTH(8), .SAT_MODE(1)) u_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_ready(s_rdy),
        .din0(din0), .din1(din1), .out_valid(s_vld), .out_ready(out_ready), .dout(s_dout), .dout_ovf(s_ovf)
    );
    case_9_mul_pipe_hs #(.dout_WIDTH(8), .SAT_MODE(0)) u_wrap (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_ready(w_rdy),
        .din0(din0), .din1(din1), .out_valid(w_vld), .out_ready(out_ready), .dout(w_dout), .dout_ovf(w_ovf)
    );
    case_9_mul_pipe_hs #(.SIGNED0(0), .SIGNED1(0)) u_uu (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_ready(u_rdy),
        .din0(din0), .din1(din1), .out_valid(u_vld), .out_ready(out_ready), .dout(u_dout), .dout_ovf(u_ovf)
    );
    case_9_mul_pipe_hs #(.SIGNED0(1), .SIGNED1(0)) u_su (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_ready(m_rdy),
        .din0(din0), .din1(din1), .out_valid(m_vld), .out_ready(out_ready), .dout(m_dout), .dout_ovf(m_ovf)
    );

    function automatic exp_t model(input logic [13:0] a, input logic [11:0] b);
        exp_t e;
        longint sa, sbb, ua, ub, ps, pu, pm;
        sa = longint'(signed'(a));
        sbb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        ps = sa * sbb;
        pu = ua * ub;
        pm = sa * ub;
        e.m = ps[25:0];
        e.s8o = (ps > 127) || (ps < -128);
        e.s8 = (ps > 127) ? 8'h7F : (ps < -128) ? 8'h80 : ps[7:0];
        e.w8 = ps[7:0];
        e.w8o = e.s8o;
        e.uu = pu[25:0];
        e.su = pm[25:0];
        e.suo = (pm >= 64'sd33554432) || (pm < -64'sd33554432);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: handshakes are sampled on the falling edge, inputs change 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge ap_clk);
        if (ap_rst_n && ce && in_valid && in_ready) exp_q.push_back(model(din0, din1));
        if (ap_rst_n && ce && out_valid && out_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_main", dout, e.m);
                chk("sb_main_ovf", dout_ovf, 0);
                chk("sb_side_valid", {s_vld, w_vld, u_vld, m_vld}, 4'hF);
                chk("sb_sat", s_dout, e.s8);
                chk("sb_sat_ovf", s_ovf, e.s8o);
                chk("sb_wrap", w_dout, e.w8);
                chk("sb_wrap_ovf", w_ovf, e.w8o);
                chk("sb_uu", u_dout, e.uu);
                chk("sb_uu_ovf", u_ovf, 0);
                chk("sb_su", m_dout, e.su);
                chk("sb_su_ovf", m_ovf, e.suo);
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run_one(input logic [13:0] a, input logic [11:0] b);
        int w = 0;
        din0 = a;
        din1 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && w < 8) begin
            tick();
            w++;
        end
        chk("run_one_valid", out_valid, 1);
    endtask

    initial begin
        int lat, acc, j, stale;
        logic [11:0] hist;
        ap_rst_n = 1'b0;
        ce = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        din0 = '0;
        din1 = '0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ovf", dout_ovf, 0);
        chk("rst_in_ready", in_ready, 0);
        ap_rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        din0 = 14'h3FFD;
        din1 = 12'h005;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("t1_latency", lat, 3);
        chk("t1_dout", dout, 26'h3FFFFF1);
        chk("t1_ovf", dout_ovf, 0);
        tick();
        chk("t1_drop", out_valid, 0);

        hist = '0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            din0 = 14'(i);
            din1 = 12'(i + 1);
            if (i < 8) chk("t2_in_ready", in_ready, 1);
            tick();
            hist[i] = out_valid;
        end
        chk("t2_valid_run", hist, 12'b0011_1111_1100);

        in_valid = 1'b1;
        out_ready = 1'b0;
        acc = 0;
        j = 0;
        din0 = 14'd20;
        din1 = 12'd3;
        for (int t = 0; t < 10; t++) begin
            if (in_ready) acc++;
            tick();
            if (acc > j) begin
                j = acc;
                din0 = 14'(20 + j);
            end
        end
        chk("t3_accepted", acc, 3);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_out_valid", out_valid, 1);
        chk("t3_dout_held", dout, 26'd60);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_idle", out_valid, 0);

        run_one(14'd100, 12'd100);
        chk("t4_sat_pos", s_dout, 8'd127);
        chk("t4_sat_pos_ovf", s_ovf, 1);
        chk("t4_wrap_pos", w_dout, 8'h10);
        chk("t4_wrap_pos_ovf", w_ovf, 1);
        tick();
        run_one(14'h3F9C, 12'd100);
        chk("t4_sat_neg", s_dout, 8'h80);
        chk("t4_sat_neg_ovf", s_ovf, 1);
        chk("t4_wrap_neg", w_dout, 8'hF0);
        tick();
        run_one(14'd10, 12'hFFB);
        chk("t4_sat_inrange", s_dout, 8'hCE);
        chk("t4_sat_inrange_ovf", s_ovf, 0);
        tick();
        run_one(14'h3FFF, 12'hFFF);
        chk("t5_uu", u_dout, 26'h3FFB001);
        chk("t5_uu_ovf", u_ovf, 0);
        chk("t5_su", m_dout, 26'h3FFF001);
        chk("t5_main", dout, 26'd1);
        tick();
        run_one(14'h2000, 12'h800);
        chk("t5_extreme", dout, 26'h1000000);
        tick();
        chk("t5_drained", exp_q.size(), 0);

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din0 = 14'(7 + i);
            din1 = 12'(9 + i);
            tick();
        end
        din0 = 14'd10;
        din1 = 12'd12;
        chk("t6_pre_valid", out_valid, 1);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_ce_in_ready", in_ready, 0);
            chk("t6_ce_valid", out_valid, 1);
            chk("t6_ce_dout", dout, 26'd63);
        end
        ce = 1'b1;
        in_valid = 1'b0;
        repeat (6) tick();
        chk("t6_ce_drained", exp_q.size(), 0);

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din0 = 14'(3 + i);
            din1 = 12'(4 + i);
            tick();
        end
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_dout", dout, 0);
        chk("t6_rst_ovf", dout_ovf, 0);
        chk("t6_rst_sat_dout", s_dout, 0);
        exp_q.delete();
        ap_rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            stale += int'(out_valid);
        end
        chk("t6_no_stale", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
